// File: rtl/md_sched.sv
// Multiply/divide sequencer: runs one MD op at a time over a fixed latency and owns HI/LO.
// Optional build macro MD_MADD_EN adds MADD/MADDU (accumulate into HI/LO).
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Decode of the incoming E-stage op
    logic w_in_mul;
    logic w_in_div;
    logic w_in_mt;
    logic w_start_eff;

`ifdef MD_MADD_EN
    assign w_in_mul = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                      (md_op == OP_MADD) || (md_op == OP_MADDU);
`else
    assign w_in_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
`endif
    assign w_in_div    = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign w_in_mt     = (md_op == OP_MTHI) || (md_op == OP_MTLO);
    assign w_start_eff = start && !busy && (w_in_mul || w_in_div || w_in_mt);

    assign busy     = (r_state == S_RUN);
    assign md_stall = D_md_use && (w_start_eff || busy);
    assign hi       = r_hi;
    assign lo       = r_lo;

    // Datapath on the latched operands
    logic        w_run_div;
    logic        w_signed;
    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_prod;
    logic [63:0] w_mul_res;

    assign w_run_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
`ifdef MD_MADD_EN
    assign w_signed  = (r_op == OP_MULT) || (r_op == OP_DIV) || (r_op == OP_MADD);
`else
    assign w_signed  = (r_op == OP_MULT) || (r_op == OP_DIV);
`endif

    // One 64-bit multiplier serves both signednesses via operand extension.
    assign w_ma   = {{32{w_signed & r_a[31]}}, r_a};
    assign w_mb   = {{32{w_signed & r_b[31]}}, r_b};
    assign w_prod = w_ma * w_mb;

`ifdef MD_MADD_EN
    assign w_mul_res = ((r_op == OP_MADD) || (r_op == OP_MADDU)) ?
                       ({r_hi, r_lo} + w_prod) : w_prod;
`else
    assign w_mul_res = w_prod;
`endif

    // Signed divide done on magnitudes; this also yields 0x80000000 / -1 = 0x80000000.
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_neg_a = w_signed & r_a[31];
    assign w_neg_b = w_signed & r_b[31];
    assign w_abs_a = w_neg_a ? (32'd0 - r_a) : r_a;
    assign w_abs_b = w_neg_b ? (32'd0 - r_b) : r_b;
    assign w_uq    = w_abs_a / w_abs_b;
    assign w_ur    = w_abs_a % w_abs_b;
    assign w_quo   = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_rem   = w_neg_a ? (32'd0 - w_ur) : w_ur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_eff) begin
                        if (w_in_mt) begin
                            if (md_op == OP_MTHI) r_hi <= A;
                            else                  r_lo <= A;
                        end else begin
                            r_a     <= A;
                            r_b     <= B;
                            r_op    <= md_op;
                            r_cnt   <= w_in_div ? DIV_N : MULT_N;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_IDLE;
                        if (w_run_div) begin
                            // Divide by zero leaves HI/LO untouched.
                            if (r_b != 32'd0) begin
                                r_hi <= w_rem;
                                r_lo <= w_quo;
                            end
                        end else begin
                            r_hi <= w_mul_res[63:32];
                            r_lo <= w_mul_res[31:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed vector table, corner sequences, and random ops vs a reference model.
module tb_md_sched;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
        .D_md_use(D_md_use), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from the current cycle, then count busy cycles (bounded).
    // noise: 0 none, 1 random start during busy, 2 MULT 2x2 during busy.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit exp_stall, input int noise, output int ncyc);
        start = 1'b1; md_op = op; A = a; B = b; D_md_use = 1'b1;
        #1;
        chk("stall_start", {31'd0, md_stall}, {31'd0, exp_stall});
        tick();
        start = 1'b0; md_op = 4'd0;
        ncyc = 0;
        while (busy && ncyc < 40) begin
            ncyc++;
            chk("stall_busy", {31'd0, md_stall}, 32'd1);
            if (noise == 1) begin
                start = 1'($urandom); md_op = 4'($urandom); A = $urandom; B = $urandom;
            end else if (noise == 2) begin
                start = 1'b1; md_op = 4'd1; A = 32'd2; B = 32'd2;
            end
            tick();
            start = 1'b0; md_op = 4'd0;
        end
        #1;
        chk("stall_done", {31'd0, md_stall}, 32'd0);
    endtask

    // Reference: architectural effect of one op on HI/LO, with plain 64-bit arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] h, inout logic [31:0] l, output int cyc);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint unsigned acc;
        cyc = 0;
        case (op)
            4'd1: begin acc = longint'(sa * sb); {h, l} = acc; cyc = MC; end
            4'd2: begin acc = ua * ub; {h, l} = acc; cyc = MC; end
            4'd3: begin
                cyc = DC;
                if (b != 0) begin l = 32'(sa / sb); h = 32'(sa % sb); end
            end
            4'd4: begin
                cyc = DC;
                if (b != 0) begin l = 32'(ua / ub); h = 32'(ua % ub); end
            end
            4'd5: h = a;
            4'd6: l = a;
`ifdef MD_MADD_EN
            4'd7: begin acc = {h, l} + longint'(sa * sb); {h, l} = acc; cyc = MC; end
            4'd8: begin acc = {h, l} + ua * ub; {h, l} = acc; cyc = MC; end
`endif
            default: cyc = 0;
        endcase
    endtask

    vec_t tbl[14];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] mh, ml;
        int mc;

        tbl[0]  = '{4'd1,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MC};
        tbl[1]  = '{4'd2,  32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, MC};
        tbl[2]  = '{4'd4,  32'd7,        32'd2,        32'h00000001, 32'h00000003, DC};
        tbl[3]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        tbl[4]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        tbl[5]  = '{4'd3,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        tbl[6]  = '{4'd5,  32'h1234,     32'd9,        32'h00001234, 32'hFFFFFFFD, 0};
        tbl[7]  = '{4'd6,  32'h5678,     32'd9,        32'h00001234, 32'h00005678, 0};
        tbl[8]  = '{4'd3,  32'd5,        32'd0,        32'h00001234, 32'h00005678, DC};
        tbl[9]  = '{4'd4,  32'd5,        32'd0,        32'h00001234, 32'h00005678, DC};
        tbl[10] = '{4'd0,  32'd9,        32'd9,        32'h00001234, 32'h00005678, 0};
        tbl[11] = '{4'd12, 32'd9,        32'd9,        32'h00001234, 32'h00005678, 0};
        tbl[12] = '{4'd1,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, MC};
        tbl[13] = '{4'd1,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};

        reset = 1'b0; start = 1'b0; md_op = 4'd0; A = 32'd0; B = 32'd0; D_md_use = 1'b1;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'd0, md_stall}, 32'd0);
        reset = 1'b1;
        tick();

        // Row 0 also carries an ignored MULT 2x2 during busy.
        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b,
                  (tbl[i].cyc > 0) || (tbl[i].op == 4'd5) || (tbl[i].op == 4'd6),
                  (i == 0) ? 2 : 0, n);
            chk($sformatf("vec%0d_cyc", i), n, tbl[i].cyc);
            chk($sformatf("vec%0d_hi", i), hi, tbl[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, tbl[i].lo);
        end

        // Asynchronous reset in the 4th busy cycle of a DIV.
        start = 1'b1; md_op = 4'd3; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0; md_op = 4'd0;
        tick(); tick(); tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        #2;
        reset = 1'b1;
        tick();
        issue(4'd1, 32'd3, 32'd4, 1'b1, 0, n);
        chk("post_rst_cyc", n, MC);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd12);

        // Accumulate sequence.
        issue(4'd6, 32'd10, 32'd0, 1'b1, 0, n);
        issue(4'd5, 32'd0,  32'd0, 1'b1, 0, n);
        chk("mthi_nobusy", n, 0);
`ifdef MD_MADD_EN
        issue(4'd7, 32'd3, 32'd4, 1'b1, 0, n);
        chk("madd_cyc", n, MC);
        chk("madd_lo", lo, 32'd22);
`else
        issue(4'd7, 32'd3, 32'd4, 1'b0, 0, n);
        chk("madd_cyc", n, 0);
        chk("madd_lo", lo, 32'd10);
`endif
        chk("madd_hi", hi, 32'd0);

        // Randomized ops, starting from a fresh reset so the model state is known.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        mh = 32'd0; ml = 32'd0;
        for (int k = 0; k < 300; k++) begin
            logic [3:0]  op;
            logic [31:0] ra, rb;
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = 32'($urandom_range(0, 20)); rb = 32'($urandom_range(0, 5)); end
                2: begin ra = $urandom; rb = 32'd0; end
                default: begin
                    ra = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
                    rb = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h80000000;
                end
            endcase
            model(op, ra, rb, mh, ml, mc);
            issue(op, ra, rb, (mc > 0) || (op == 4'd5) || (op == 4'd6), 1, n);
            chk($sformatf("rnd%0d_cyc", k), n, mc);
            chk($sformatf("rnd%0d_hi", k), hi, mh);
            chk($sformatf("rnd%0d_lo", k), lo, ml);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
